trigger_wb_initiator: RTL and testbench

- Wishbone classic initiator that turns a valid/ready command stream into single WB transactions toward the 8-channel trigger-chain targets (biquad and AGC register banks).
- Address layout toward targets: channel in adr[12:10], register in adr[7:0].
- Handles ack/err/rty terminations, bounded retries with backoff, and a per-attempt timeout.
- Returns one status/data response per command; sits between the housekeeping/command path and the trigger WB fabric.

---
 rtl/trigger_wb_pkg.sv | 23 ++
 rtl/trigger_wb_initiator.sv | 193 +++++++++++++++++++
 tb/tb_trigger_wb_initiator.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trigger_wb_pkg.sv
// Shared types and address-layout constants for the trigger-chain Wishbone initiator and target fanout.
// Channel lives at adr[CHAN_SHIFT +: CHAN_BITS], register at adr[REG_BITS-1:0].
package trigger_wb_pkg;

    typedef enum logic [1:0] {
        RSP_OK              = 2'd0,
        RSP_ERR             = 2'd1,
        RSP_TIMEOUT         = 2'd2,
        RSP_RETRY_EXHAUSTED = 2'd3
    } wb_rsp_status_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_GAP  = 2'd2,
        ST_RESP = 2'd3
    } init_state_t;

    localparam int CHAN_SHIFT = 10;
    localparam int CHAN_BITS  = 3;
    localparam int REG_BITS   = 8;

endpackage

// File: rtl/trigger_wb_initiator.sv
// Purpose: turns a valid/ready command stream into single classic WB transactions with retry and timeout.
// Latency: accept at N -> cyc at N+1; termination at N+1+k -> rsp_valid at N+2+k.
// Backpressure: one command in flight; cmd_ready only in IDLE; response held until rsp_ready_i.
module trigger_wb_initiator
    import trigger_wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 22,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRIES    = 3,
    parameter int RETRY_GAP      = 4
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_we_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_adr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_dat_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_sel_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [1:0]              rsp_status_o,
    output logic [DATA_WIDTH-1:0]   rsp_dat_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic                    wb_rty_i,
    output logic                    busy_o,
    output logic [15:0]             txn_count_o,
    output logic [15:0]             err_count_o
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int GW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP + 1) : 1;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    init_state_t           state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [SW-1:0]         sel_q, sel_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [RW-1:0]         retry_q, retry_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic                  cyc_q, cyc_d;
    logic                  rsp_vld_q, rsp_vld_d;
    logic                  busy_q, busy_d;
    wb_rsp_status_t        status_q, status_d;
    logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
    logic [15:0]           txn_q, txn_d;
    logic [15:0]           err_q, err_d;

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        tmo_d    = tmo_q;
        retry_d  = retry_q;
        gap_d    = gap_q;
        status_d = status_q;
        rdat_d   = rdat_q;
        txn_d    = txn_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    we_d     = cmd_we_i;
                    adr_d    = cmd_adr_i;
                    dat_d    = cmd_dat_i;
                    sel_d    = cmd_sel_i;
                    tmo_d    = '0;
                    retry_d  = '0;
                    status_d = RSP_OK;
                    rdat_d   = '0;
                    state_d  = ST_BUS;
                end
            end
            ST_BUS: begin
                tmo_d = tmo_q + TW'(1);
                // err beats rty beats ack when several arrive together
                if (wb_err_i) begin
                    status_d = RSP_ERR;
                    state_d  = ST_RESP;
                end else if (wb_rty_i) begin
                    if (retry_q == RW'(MAX_RETRIES)) begin
                        status_d = RSP_RETRY_EXHAUSTED;
                        state_d  = ST_RESP;
                    end else begin
                        retry_d = retry_q + RW'(1);
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end
                end else if (wb_ack_i) begin
                    status_d = RSP_OK;
                    rdat_d   = we_q ? '0 : wb_dat_i;
                    state_d  = ST_RESP;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    status_d = RSP_TIMEOUT;
                    state_d  = ST_RESP;
                end
            end
            ST_GAP: begin
                if (gap_q == GW'(RETRY_GAP - 1)) begin
                    tmo_d   = '0;
                    state_d = ST_BUS;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    txn_d = sat_inc(txn_q);
                    if (status_q != RSP_OK) begin
                        err_d = sat_inc(err_q);
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // bus/response flags follow the next state so they are registered yet aligned with it
        cyc_d     = (state_d == ST_BUS);
        rsp_vld_d = (state_d == ST_RESP);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            tmo_q     <= '0;
            retry_q   <= '0;
            gap_q     <= '0;
            cyc_q     <= 1'b0;
            rsp_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            status_q  <= RSP_OK;
            rdat_q    <= '0;
            txn_q     <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            tmo_q     <= tmo_d;
            retry_q   <= retry_d;
            gap_q     <= gap_d;
            cyc_q     <= cyc_d;
            rsp_vld_q <= rsp_vld_d;
            busy_q    <= busy_d;
            status_q  <= status_d;
            rdat_q    <= rdat_d;
            txn_q     <= txn_d;
            err_q     <= err_d;
        end
    end

    assign cmd_ready_o  = (state_q == ST_IDLE);
    assign rsp_valid_o  = rsp_vld_q;
    assign rsp_status_o = status_q;
    assign rsp_dat_o    = rdat_q;
    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = cyc_q;
    assign wb_we_o      = we_q;
    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = dat_q;
    assign wb_sel_o     = sel_q;
    assign busy_o       = busy_q;
    assign txn_count_o  = txn_q;
    assign err_count_o  = err_q;

endmodule

// File: tb/tb_trigger_wb_initiator.sv
// Randomized bench for trigger_wb_initiator: a scripted WB target plus a cycle-trace reference model.
module tb_trigger_wb_initiator;

    localparam int AW   = 22;
    localparam int DW   = 32;
    localparam int TMO  = 255;
    localparam int MAXR = 3;
    localparam int GAPC = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic          cmd_we_i = 1'b0;
    logic [AW-1:0] cmd_adr_i = '0;
    logic [DW-1:0] cmd_dat_i = '0;
    logic [3:0]    cmd_sel_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [1:0]    rsp_status_o;
    logic [DW-1:0] rsp_dat_o;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [3:0]    wb_sel_o;
    logic [DW-1:0] wb_dat_i = '0;
    logic          wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;
    logic          busy_o;
    logic [15:0]   txn_count_o, err_count_o;

    trigger_wb_initiator #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO),
        .MAX_RETRIES(MAXR), .RETRY_GAP(GAPC)
    ) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_status_o(rsp_status_o), .rsp_dat_o(rsp_dat_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
        .busy_o(busy_o), .txn_count_o(txn_count_o), .err_count_o(err_count_o)
    );

    always #5 clk = ~clk;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    // Target script. Modes: 0 rty for the first tgt_rty_n attempts then ack, 1 err, 2 ack+err, 3 silent, 4 ack+rty.
    int          tgt_mode = 0;
    int          tgt_rty_n = 0;
    int          tgt_delay = 0;
    int          tgt_attempts = 0;
    bit          tgt_noise = 1'b0;
    logic [31:0] tgt_rdata = '0;

    initial begin : target
        bit in_att;
        int att_cyc;
        in_att  = 1'b0;
        att_cyc = 0;
        forever begin
            @(negedge clk);
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            wb_rty_i = 1'b0;
            wb_dat_i = $urandom;
            if (wb_cyc_o && wb_stb_o) begin
                if (!in_att) begin
                    in_att = 1'b1;
                    att_cyc = 0;
                    tgt_attempts++;
                end else begin
                    att_cyc++;
                end
                if (att_cyc == tgt_delay) begin
                    case (tgt_mode)
                        0: if (tgt_attempts <= tgt_rty_n) wb_rty_i = 1'b1;
                           else begin wb_ack_i = 1'b1; wb_dat_i = tgt_rdata; end
                        1: wb_err_i = 1'b1;
                        2: begin wb_ack_i = 1'b1; wb_err_i = 1'b1; end
                        4: begin wb_ack_i = 1'b1; wb_rty_i = 1'b1; end
                        default: ;
                    endcase
                end
            end else begin
                in_att = 1'b0;
                if (tgt_noise) {wb_ack_i, wb_err_i, wb_rty_i} = 3'($urandom_range(0, 7));
            end
        end
    end

    // Reference model: expected per-cycle cyc trace from acceptance to response, plus status.
    bit got_trace[$];
    bit exp_trace[$];
    int exp_txn = 0;
    int exp_err = 0;

    task automatic build_exp(input int mode, input int rty_n, input int delay,
                             output int status, output int n_att);
        int len;
        exp_trace.delete();
        case (mode)
            0: begin
                n_att  = (rty_n > MAXR) ? MAXR + 1 : rty_n + 1;
                status = (rty_n > MAXR) ? 3 : 0;
            end
            1, 2: begin n_att = 1; status = 1; end
            3: begin n_att = 1; status = 2; end
            default: begin n_att = MAXR + 1; status = 3; end
        endcase
        len = (mode == 3) ? TMO : delay + 1;
        for (int a = 0; a < n_att; a++) begin
            if (a > 0) for (int g = 0; g < GAPC; g++) exp_trace.push_back(1'b0);
            for (int c = 0; c < len; c++) exp_trace.push_back(1'b1);
        end
    endtask

    function automatic bit trace_eq();
        if (got_trace.size() != exp_trace.size()) return 1'b0;
        foreach (got_trace[i]) if (got_trace[i] != exp_trace[i]) return 1'b0;
        return 1'b1;
    endfunction

    bit          got_to, got_stable, got_hold_ok, got_post_idle;
    logic [1:0]  got_status;
    logic [31:0] got_dat;

    // Issues one command from IDLE, records the cyc trace, holds off rsp_ready for 'hold' cycles, then consumes.
    task automatic do_cmd(input logic we, input logic [AW-1:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int hold);
        int cnt;
        got_trace.delete();
        got_to = 1'b0; got_stable = 1'b1; got_hold_ok = 1'b1; got_post_idle = 1'b0;
        tgt_attempts = 0;
        @(negedge clk);
        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
        @(posedge clk);
        @(negedge clk);
        cmd_valid_i = 1'b0; cmd_we_i = ~we; cmd_adr_i = ~adr; cmd_dat_i = ~dat; cmd_sel_i = ~sel;
        cnt = 0;
        while (!rsp_valid_o && cnt < 3000) begin
            got_trace.push_back(wb_cyc_o);
            if (wb_cyc_o !== wb_stb_o) got_stable = 1'b0;
            if (wb_cyc_o && (wb_we_o !== we || wb_adr_o !== adr || wb_dat_o !== dat || wb_sel_o !== sel))
                got_stable = 1'b0;
            @(negedge clk);
            cnt++;
        end
        if (!rsp_valid_o) begin
            got_to = 1'b1;
            return;
        end
        got_status = rsp_status_o;
        got_dat    = rsp_dat_o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid_o !== 1'b1 || rsp_status_o !== got_status || rsp_dat_o !== got_dat ||
                cmd_ready_o !== 1'b0 || busy_o !== 1'b1 || wb_cyc_o !== 1'b0)
                got_hold_ok = 1'b0;
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        got_post_idle = (cmd_ready_o === 1'b1) && (rsp_valid_o === 1'b0) && (busy_o === 1'b0);
    endtask

    task automatic test_reset();
        vec_cnt++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid_o, busy_o, rsp_status_o} !== 7'b0) begin
            miss_cnt++;
            $display("FAIL reset_outputs: got cyc=%b stb=%b we=%b rsp_vld=%b busy=%b st=%0d, required all 0",
                     wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid_o, busy_o, rsp_status_o);
        end
        vec_cnt++;
        if (txn_count_o !== 16'd0 || err_count_o !== 16'd0 || rsp_dat_o !== 32'd0 || wb_adr_o !== '0) begin
            miss_cnt++;
            $display("FAIL reset_counters: got txn=%0d err=%0d dat=%h adr=%h, required 0",
                     txn_count_o, err_count_o, rsp_dat_o, wb_adr_o);
        end
        vec_cnt++;
        if (cmd_ready_o !== 1'b1) begin
            miss_cnt++;
            $display("FAIL reset_ready: got %b, required 1", cmd_ready_o);
        end
    endtask

    task automatic test_write_ack();
        int es, na;
        tgt_mode = 0; tgt_rty_n = 0; tgt_delay = 2; tgt_noise = 1'b0; tgt_rdata = 32'hCAFEF00D;
        build_exp(0, 0, 2, es, na);
        do_cmd(1'b1, 22'h000C04, 32'hDEADBEEF, 4'hF, 0);
        exp_txn++;
        vec_cnt++;
        if (got_to || !trace_eq() || !got_stable) begin
            miss_cnt++;
            $display("FAIL write_trace: got %0d cycles to rsp (timeout=%b stable=%b), required %0d stable",
                     got_trace.size(), got_to, got_stable, exp_trace.size());
        end
        vec_cnt++;
        if (got_status !== 2'd0 || got_dat !== 32'd0) begin
            miss_cnt++;
            $display("FAIL write_rsp: got st=%0d dat=%h, required st=0 dat=0", got_status, got_dat);
        end
        vec_cnt++;
        if (txn_count_o !== 16'(exp_txn) || err_count_o !== 16'(exp_err) || !got_post_idle) begin
            miss_cnt++;
            $display("FAIL write_counts: got txn=%0d err=%0d idle=%b, required txn=%0d err=%0d idle=1",
                     txn_count_o, err_count_o, got_post_idle, exp_txn, exp_err);
        end
    endtask

    task automatic test_read_zero_wait();
        int es, na;
        tgt_mode = 0; tgt_rty_n = 0; tgt_delay = 0; tgt_noise = 1'b0; tgt_rdata = 32'h12345678;
        build_exp(0, 0, 0, es, na);
        do_cmd(1'b0, 22'h001404, 32'h0, 4'hF, 1);
        exp_txn++;
        vec_cnt++;
        if (got_to || got_trace.size() != 1 || !trace_eq() || !got_stable) begin
            miss_cnt++;
            $display("FAIL read_latency: got rsp %0d cycles after accept, required 2", got_trace.size() + 1);
        end
        vec_cnt++;
        if (got_status !== 2'd0 || got_dat !== 32'h12345678) begin
            miss_cnt++;
            $display("FAIL read_rsp: got st=%0d dat=%h, required st=0 dat=12345678", got_status, got_dat);
        end
    endtask

    task automatic test_retry_exhausted();
        int es, na;
        tgt_mode = 0; tgt_rty_n = 100; tgt_delay = 1; tgt_noise = 1'b1;
        build_exp(0, 100, 1, es, na);
        do_cmd(1'b1, 22'h002410, 32'h0BADF00D, 4'h3, 2);
        exp_txn++; exp_err++;
        vec_cnt++;
        if (got_to || !trace_eq() || tgt_attempts != 4) begin
            miss_cnt++;
            $display("FAIL retry_trace: got %0d cycles, %0d attempts, required %0d cycles, 4 attempts",
                     got_trace.size(), tgt_attempts, exp_trace.size());
        end
        vec_cnt++;
        if (got_status !== 2'd3 || got_dat !== 32'd0 || err_count_o !== 16'(exp_err)) begin
            miss_cnt++;
            $display("FAIL retry_rsp: got st=%0d dat=%h err=%0d, required st=3 dat=0 err=%0d",
                     got_status, got_dat, err_count_o, exp_err);
        end
        tgt_noise = 1'b0;
    endtask

    task automatic test_timeout();
        int es, na;
        tgt_mode = 3; tgt_delay = 0;
        build_exp(3, 0, 0, es, na);
        do_cmd(1'b0, 22'h001C08, 32'h0, 4'hF, 3);
        exp_txn++; exp_err++;
        vec_cnt++;
        if (got_to || !trace_eq()) begin
            miss_cnt++;
            $display("FAIL timeout_trace: got %0d cycles to rsp, required %0d", got_trace.size(), exp_trace.size());
        end
        vec_cnt++;
        if (got_status !== 2'd2 || !got_hold_ok || !got_post_idle) begin
            miss_cnt++;
            $display("FAIL timeout_rsp: got st=%0d hold_ok=%b idle=%b, required st=2 1 1",
                     got_status, got_hold_ok, got_post_idle);
        end
    endtask

    task automatic test_ack_err_stall();
        int es, na;
        tgt_mode = 2; tgt_delay = 1; tgt_rdata = 32'h55AA55AA;
        build_exp(2, 0, 1, es, na);
        do_cmd(1'b0, 22'h000408, 32'h0, 4'hF, 10);
        exp_txn++; exp_err++;
        vec_cnt++;
        if (got_to || !trace_eq() || got_status !== 2'd1 || got_dat !== 32'd0) begin
            miss_cnt++;
            $display("FAIL ack_err: got st=%0d dat=%h cycles=%0d, required st=1 dat=0 cycles=%0d",
                     got_status, got_dat, got_trace.size(), exp_trace.size());
        end
        vec_cnt++;
        if (!got_hold_ok) begin
            miss_cnt++;
            $display("FAIL stall_hold: got unstable response or cmd_ready during stall, required stable");
        end
        vec_cnt++;
        if (txn_count_o !== 16'(exp_txn) || err_count_o !== 16'(exp_err)) begin
            miss_cnt++;
            $display("FAIL stall_counts: got txn=%0d err=%0d, required txn=%0d err=%0d",
                     txn_count_o, err_count_o, exp_txn, exp_err);
        end
    endtask

    task automatic test_reset_mid_bus();
        int es, na;
        tgt_mode = 3; tgt_delay = 0; tgt_attempts = 0;
        @(negedge clk);
        cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 22'h003000; cmd_dat_i = 32'h1; cmd_sel_i = 4'h1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        repeat (5) @(negedge clk);
        vec_cnt++;
        if (wb_cyc_o !== 1'b1) begin
            miss_cnt++;
            $display("FAIL midbus_pre: got cyc=%b, required 1", wb_cyc_o);
        end
        #2 rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({wb_cyc_o, wb_stb_o, rsp_valid_o, busy_o} !== 4'b0 || txn_count_o !== 16'd0 ||
            err_count_o !== 16'd0) begin
            miss_cnt++;
            $display("FAIL midbus_async: got cyc=%b stb=%b rsp=%b busy=%b txn=%0d err=%0d, required 0",
                     wb_cyc_o, wb_stb_o, rsp_valid_o, busy_o, txn_count_o, err_count_o);
        end
        exp_txn = 0; exp_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            miss_cnt++;
            $display("FAIL midbus_lost: got rsp=%b ready=%b, required 0 1", rsp_valid_o, cmd_ready_o);
        end
        tgt_mode = 0; tgt_rty_n = 1; tgt_delay = 1; tgt_rdata = 32'hA5A5F00F;
        build_exp(0, 1, 1, es, na);
        do_cmd(1'b0, 22'h001C7F, 32'h0, 4'hF, 0);
        exp_txn++;
        vec_cnt++;
        if (got_to || !trace_eq() || got_status !== 2'd0 || got_dat !== 32'hA5A5F00F ||
            txn_count_o !== 16'(exp_txn)) begin
            miss_cnt++;
            $display("FAIL midbus_after: got st=%0d dat=%h txn=%0d cycles=%0d, required st=0 dat=a5a5f00f txn=%0d cycles=%0d",
                     got_status, got_dat, txn_count_o, got_trace.size(), exp_txn, exp_trace.size());
        end
    endtask

    task automatic test_random();
        int es, na, r, hold;
        logic          we;
        logic [AW-1:0] adr;
        logic [31:0]   dat, edat;
        logic [3:0]    sel;
        for (int it = 0; it < 25; it++) begin
            r = $urandom_range(0, 15);
            tgt_mode  = (r < 8) ? 0 : (r < 10) ? 1 : (r < 12) ? 2 : (r < 13) ? 3 : 4;
            tgt_rty_n = $urandom_range(0, 5);
            tgt_delay = $urandom_range(0, 3);
            tgt_noise = 1'($urandom_range(0, 1));
            tgt_rdata = $urandom;
            we   = 1'($urandom_range(0, 1));
            adr  = 22'($urandom);
            dat  = $urandom;
            sel  = 4'($urandom);
            hold = $urandom_range(0, 3);
            build_exp(tgt_mode, tgt_rty_n, tgt_delay, es, na);
            edat = (es == 0 && !we) ? tgt_rdata : 32'd0;
            do_cmd(we, adr, dat, sel, hold);
            exp_txn++;
            if (es != 0) exp_err++;
            vec_cnt++;
            if (got_to || !trace_eq() || !got_stable || tgt_attempts != na) begin
                miss_cnt++;
                $display("FAIL rand%0d_trace: mode=%0d got %0d cycles %0d attempts stable=%b, required %0d cycles %0d attempts",
                         it, tgt_mode, got_trace.size(), tgt_attempts, got_stable, exp_trace.size(), na);
            end
            vec_cnt++;
            if (got_status !== 2'(es) || got_dat !== edat) begin
                miss_cnt++;
                $display("FAIL rand%0d_rsp: mode=%0d got st=%0d dat=%h, required st=%0d dat=%h",
                         it, tgt_mode, got_status, got_dat, es, edat);
            end
            vec_cnt++;
            if (!got_hold_ok || !got_post_idle || txn_count_o !== 16'(exp_txn) ||
                err_count_o !== 16'(exp_err)) begin
                miss_cnt++;
                $display("FAIL rand%0d_cnt: hold=%b idle=%b txn=%0d err=%0d, required 1 1 txn=%0d err=%0d",
                         it, got_hold_ok, got_post_idle, txn_count_o, err_count_o, exp_txn, exp_err);
            end
        end
        tgt_noise = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_write_ack();
        test_read_zero_wait();
        test_retry_exhausted();
        test_timeout();
        test_ack_err_stall();
        test_reset_mid_bus();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
